// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory responder
package dmem_pkg;

  localparam int DMEM_LATENCY     = 4;
  localparam int DMEM_DEPTH_WORDS = 256;
  localparam int CNT_W            = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - pipeline <-> data-memory bus; misalign_o exists only with DMEM_ALIGN_CHECK_EN
interface dmem_if;

  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i,
    input  stall_o, done_o, rdata_o, misalign_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i,
    output stall_o, done_o, rdata_o, misalign_o
  );
`else
  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i,
    input  stall_o, done_o, rdata_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i,
    output stall_o, done_o, rdata_o
  );
`endif

endinterface

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port word array, synchronous write, registered read
module dmem_sram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic          clr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read register only moves on a read or a clear, so it holds across writes.
  always_comb begin
    rdata_d = rdata_q;
    if (clr_i) begin
      rdata_d = '0;
    end else if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory FSM; DMEM_ALIGN_CHECK_EN enables misalignment trapping
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY     = DMEM_LATENCY,
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic  clk_i,
  input  logic  rst_i,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             req;
  logic             stall;
  logic             done;
  logic             sram_we;
  logic             sram_re;
  logic             sram_clr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic             misalign_q, misalign_d;
`endif

  assign req = bus.MemRead_i | bus.MemWrite_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    stall    = 1'b0;
    done     = 1'b0;
    sram_we  = 1'b0;
    sram_re  = 1'b0;
    sram_clr = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          // Write wins when both strobes are high.
          is_wr_d = bus.MemWrite_i;
          addr_d  = bus.addr_i[AW+1:2];
          wdata_d = bus.wdata_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
`ifdef DMEM_ALIGN_CHECK_EN
          misalign_d = 1'b0;
          if (bus.addr_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            sram_clr   = 1'b1;
            state_d    = DONE;
          end
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          sram_we = is_wr_q;
          sram_re = ~is_wr_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts any in-flight access before it can touch the array.
    if (rst_i) begin
      stall    = 1'b0;
      sram_we  = 1'b0;
      sram_re  = 1'b0;
      sram_clr = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.misalign_o = done & misalign_q;
`endif

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (sram_we),
    .re_i    (sram_re),
    .clr_i   (sram_clr),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.rdata_o)
  );

  assign bus.stall_o = stall;
  assign bus.done_o  = done;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder with LATENCY=4, DEPTH_WORDS=256
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_if dif ();

  dmem_responder #(
    .LATENCY     (4),
    .DEPTH_WORDS (256)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_req();
    dif.MemRead_i  = 1'b0;
    dif.MemWrite_i = 1'b0;
    dif.addr_i     = '0;
    dif.wdata_i    = '0;
  endtask

  // One request; k counts cycles from acceptance (k=0 is cycle T).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int stall_n,
                        output int done_at, output logic [31:0] rd_at_done);
    stall_n    = 0;
    done_at    = -1;
    rd_at_done = '0;
    @(negedge clk);
    dif.MemRead_i  = rd;
    dif.MemWrite_i = wr;
    dif.addr_i     = a;
    dif.wdata_i    = wd;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (dif.stall_o) stall_n++;
      if (dif.done_o) begin
        done_at    = k;
        rd_at_done = dif.rdata_o;
        break;
      end
      @(posedge clk);
      #1;
      clear_req();
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_req();
    repeat (2) @(posedge clk);
    @(negedge clk);
    dif.MemWrite_i = 1'b1;
    dif.addr_i     = 32'h40;
    #1;
    checks++;
    if (dif.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%b exp=0", dif.stall_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dif.rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=00000000", dif.rdata_o);
    end
    checks++;
    if (dif.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", dif.done_o);
    end
    @(negedge clk);
    clear_req();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_stall got=%b exp=0", dif.stall_o);
    end
  endtask

  task automatic test_write();
    int s, d;
    logic [31:0] r;
    access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, s, d, r);
    checks++;
    if (s !== 5) begin
      errors++;
      $display("FAIL write_stall_cycles got=%0d exp=5", s);
    end
    checks++;
    if (d !== 5) begin
      errors++;
      $display("FAIL write_done_cycle got=%0d exp=5", d);
    end
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL write_rdata got=%h exp=00000000", r);
    end
  endtask

  task automatic test_read();
    int s, d;
    logic [31:0] r;
    access(1'b1, 1'b0, 32'h40, 32'h0, s, d, r);
    checks++;
    if (d !== 5) begin
      errors++;
      $display("FAIL read_done_cycle got=%0d exp=5", d);
    end
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_data got=%h exp=deadbeef", r);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dif.rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_hold got=%h exp=deadbeef", dif.rdata_o);
    end
  endtask

  task automatic test_alias();
    int s, d;
    logic [31:0] r;
    access(1'b0, 1'b1, 32'h400, 32'h11111111, s, d, r);
    access(1'b1, 1'b0, 32'h000, 32'h0, s, d, r);
    checks++;
    if (r !== 32'h11111111) begin
      errors++;
      $display("FAIL alias_read got=%h exp=11111111", r);
    end
  endtask

  task automatic test_both_high();
    int s, d;
    logic [31:0] r;
    access(1'b1, 1'b1, 32'h8, 32'h5, s, d, r);
    checks++;
    if (r !== 32'h11111111) begin
      errors++;
      $display("FAIL both_rdata_unchanged got=%h exp=11111111", r);
    end
    access(1'b1, 1'b0, 32'h8, 32'h0, s, d, r);
    checks++;
    if (r !== 32'h5) begin
      errors++;
      $display("FAIL both_readback got=%h exp=00000005", r);
    end
  endtask

  task automatic test_reset_abort();
    int s, d;
    int bad;
    logic [31:0] r;
    access(1'b0, 1'b1, 32'h10, 32'h0, s, d, r);
    @(negedge clk);
    dif.MemWrite_i = 1'b1;
    dif.addr_i     = 32'h10;
    dif.wdata_i    = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    clear_req();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dif.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_stall_in_reset got=%b exp=0", dif.stall_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dif.done_o !== 1'b0 || dif.stall_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d busy_cycles exp=0", bad);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, s, d, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL abort_no_commit got=%h exp=00000000", r);
    end
  endtask

  task automatic test_back_to_back();
    int done1, done2, stall6;
    logic [31:0] r;
    done1  = -1;
    done2  = -1;
    stall6 = -1;
    r      = '0;
    @(negedge clk);
    dif.MemRead_i = 1'b1;
    dif.addr_i    = 32'h40;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (dif.done_o) begin
        if (done1 < 0) begin
          done1 = k;
          r     = dif.rdata_o;
        end else if (done2 < 0) begin
          done2 = k;
        end
      end
      if (k == 6) stall6 = int'(dif.stall_o);
      @(negedge clk);
      #1;
    end
    clear_req();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done1 !== 5) begin
      errors++;
      $display("FAIL b2b_first_done got=%0d exp=5", done1);
    end
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_first_data got=%h exp=deadbeef", r);
    end
    checks++;
    if (stall6 !== 1) begin
      errors++;
      $display("FAIL b2b_reaccept_stall got=%0d exp=1", stall6);
    end
    checks++;
    if (done2 !== 11) begin
      errors++;
      $display("FAIL b2b_second_done got=%0d exp=11", done2);
    end
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    int s, d;
    logic [31:0] r;
    logic mis;
    @(negedge clk);
    dif.MemRead_i = 1'b1;
    dif.addr_i    = 32'h42;
    #1;
    s = int'(dif.stall_o);
    @(posedge clk);
    #1;
    clear_req();
    @(negedge clk);
    d   = int'(dif.done_o);
    mis = dif.misalign_o;
    r   = dif.rdata_o;
    checks++;
    if (s !== 1 || d !== 1 || mis !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL misalign got stall=%0d done=%0d mis=%b rdata=%h exp 1 1 1 00000000", s, d, mis, r);
    end
    @(posedge clk);
    access(1'b1, 1'b0, 32'h40, 32'h0, s, d, r);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL misalign_mem_untouched got=%h exp=deadbeef", r);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_req();
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
`ifdef DMEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_alias();
    test_both_high();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 4, memory access latency in cycles (legal range 1..15).
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the array (power of two).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 MemRead_i  input  1  read request from the EX/MEM pipeline register.
REQ-006 MemWrite_i  input  1  write request from the EX/MEM pipeline register.
REQ-007 addr_i  input  32  byte address (ALU result).
REQ-008 wdata_i  input  32  store data (RS2 data).
REQ-009 stall_o  output  1  high: pipeline SHALL hold the PC and IF/ID, ID/EX, EX/MEM registers.
REQ-010 done_o  output  1  one-cycle pulse: access complete.
REQ-011 rdata_o  output  32  load data, valid when done_o is high after a read.
REQ-012 misalign_o  output  1  present only with DMEM_ALIGN_CHECK_EN; pulses with done_o on a misaligned access.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with MemRead_i or MemWrite_i high at cycle T: latch op/addr/wdata, load a 4-bit counter with LATENCY-1, and go to BUSY.
REQ-015 stall_o SHALL be combinationally high in IDLE while a request is present, and high throughout BUSY.
REQ-016 In BUSY: if counter == 0, commit the access and go to DONE; otherwise decrement the counter.
REQ-017 In DONE: done_o = 1, stall_o = 0, inputs ignored; the state SHALL return to IDLE unconditionally on the next cycle.
REQ-018 Timing: stall_o high for cycles T..T+LATENCY; done_o high at cycle T+LATENCY+1.
REQ-019 The write SHALL commit on the BUSY->DONE edge, using the latched address and data.
REQ-020 Read data SHALL be registered on the BUSY->DONE edge; rdata_o SHALL hold until the next read completes.
REQ-021 A write SHALL leave rdata_o unchanged.
REQ-022 With MemRead_i and MemWrite_i both high, the request SHALL be treated as a write.
REQ-023 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; higher bits ignored, so addresses alias modulo DEPTH_WORDS*4.
REQ-024 Back-to-back requests SHALL incur one idle-free gap: DONE -> IDLE -> accept at the earliest.

Reset
REQ-025 While rst_i is high at a rising edge: state = IDLE, counter = 0, rdata_o = 0, done_o = 0, misalign_o = 0.
REQ-026 stall_o SHALL be 0 in the reset cycle.
REQ-027 Reset during BUSY SHALL abort the access, and a pending write SHALL NOT commit.
REQ-028 Array contents SHALL NOT be reset and are undefined until written.

Configuration
REQ-029 The macro DMEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-030 When DMEM_ALIGN_CHECK_EN is defined: a request with addr_i[1:0] != 0 SHALL go IDLE -> DONE directly (stall_o high only in cycle T), with no array access, rdata_o forced to 0, and misalign_o = 1 in DONE.
REQ-031 When DMEM_ALIGN_CHECK_EN is not defined: the misalign_o port SHALL be absent, addr_i[1:0] SHALL be ignored, and all accesses SHALL follow REQ-014..REQ-023.

Structure
REQ-032 Package dmem_pkg SHALL hold the state enum (IDLE/BUSY/DONE), the default LATENCY and DEPTH_WORDS constants, and the counter width constant (4).
REQ-033 Sub-module dmem_sram SHALL implement the single-port array: synchronous write with a write-enable, registered read, and parameter DEPTH_WORDS.
REQ-034 dmem_responder SHALL contain only the FSM, the counter, the request latches and the output logic.

Verification
REQ-035 Reset, then write 0xDEADBEEF to 0x40 with LATENCY=4 -> stall_o high for 5 cycles, done_o pulses at cycle T+5, rdata_o stays 0.
REQ-036 Read 0x40 after REQ-035 -> done_o pulses at T+5 with rdata_o = 0xDEADBEEF, and rdata_o holds it afterwards.
REQ-037 With DEPTH_WORDS=256, write 0x11111111 to 0x400, then read 0x000 -> rdata_o = 0x11111111 (aliasing).
REQ-038 MemRead_i and MemWrite_i both high, addr 0x8, wdata 0x5 -> treated as write, rdata_o unchanged; a later read of 0x8 returns 0x5.
REQ-039 Start a write of 0xCAFEF00D to 0x10 (addr previously 0x0), assert rst_i in the 2nd BUSY cycle -> state returns to IDLE, no done_o, a later read of 0x10 returns 0x0.
REQ-040 With DMEM_ALIGN_CHECK_EN, read 0x42 -> stall_o high for 1 cycle, then done_o = misalign_o = 1 and rdata_o = 0, with memory untouched.
